// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: eight packet requesters share one output channel.
// A requester owns the channel from its grant until its last beat has
// transferred. A 3-bit rotating pointer records where the next
// arbitration scan starts, so all requesters are served fairly.
// Each packet pays a one-cycle IDLE bubble while the next owner is chosen.
module mux8_rr_arbiter #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_valid,
  input  logic [7:0]         in_last,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [2:0]         sel,
  output logic               busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [2:0] ptr;
  logic [2:0] next_ptr;
  logic [2:0] next_sel;
  logic [2:0] pick_idx;
  logic [2:0] cand;

  assign busy = (state == BUSY);

  // The mux always follows sel, so data and last keep being driven in IDLE
  // and out_valid alone says whether the channel carries a beat.
  assign out_data  = in_data[sel*WIDTH +: WIDTH];
  assign out_last  = in_last[sel];
  assign out_valid = busy & in_valid[sel];

  // Only the owner sees out_ready, and never while IDLE; ready ignores in_valid.
  always_comb begin
    in_ready = '0;
    if (busy) begin
      in_ready[sel] = out_ready;
    end
  end

  // Round-robin scan from ptr upward; the loop runs from the farthest offset
  // down so the closest requesting index is the one left in pick_idx.
  always_comb begin
    pick_idx = ptr;
    cand     = ptr;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr + 3'(k);
      if (in_valid[cand]) begin
        pick_idx = cand;
      end
    end
  end

  // Next-state logic: grant in IDLE, release after a transferred last beat.
  always_comb begin
    next_state = state;
    next_sel   = sel;
    next_ptr   = ptr;
    case (state)
      IDLE: begin
        if (|in_valid) begin
          next_state = BUSY;
          next_sel   = pick_idx;
        end
      end
      BUSY: begin
        if (out_valid && out_ready && out_last) begin
          next_state = IDLE;
          next_ptr   = sel + 3'd1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, owner and scan-pointer registers; reset abandons any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 3'd0;
      ptr   <= 3'd0;
    end else begin
      state <= next_state;
      sel   <= next_sel;
      ptr   <= next_ptr;
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed scenarios checked against constants derived
// from the arbitration rules, then a long random run checked every cycle
// against a behavioural model (owner, busy flag, next-scan start).
module tb_mux8_rr_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   in_valid = '0;
  logic [7:0]   in_last = '0;
  logic [8*W-1:0] in_data = '0;
  logic [7:0]   in_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;
  logic [2:0]   sel;
  logic         busy;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;

  // Model expectations for the current cycle
  logic         e_busy;
  logic [2:0]   e_sel;
  logic         e_valid;
  logic [7:0]   e_ready;
  logic [W-1:0] e_data;
  logic         e_last;

  mux8_rr_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .sel       (sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // First requester at or after p, wrapping modulo 8
  function automatic int pick(input logic [7:0] v, input int p);
    for (int k = 0; k < 8; k++) begin
      if (v[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] lane(input int i);
    return in_data[i*W +: W];
  endfunction

  // Drive one cycle of inputs (called just after a rising edge) and form
  // the model's expected outputs for that cycle.
  task automatic apply_stimulus(input logic [7:0] v, input logic [7:0] l, input logic r);
    in_valid  = v;
    in_last   = l;
    out_ready = r;
    in_data   = {$urandom, $urandom};
    e_busy  = m_busy;
    e_sel   = 3'(m_owner);
    e_valid = m_busy && v[m_owner];
    e_ready = (m_busy && r) ? 8'(1 << m_owner) : 8'h00;
    e_data  = in_data[m_owner*W +: W];
    e_last  = l[m_owner];
    #3;
  endtask

  // Advance the model by the rules, then let the DUT take the same edge.
  task automatic advance_clock();
    if (!m_busy) begin
      if (in_valid != 8'h00) begin
        m_owner = pick(in_valid, m_ptr);
        m_busy  = 1'b1;
      end
    end else if (e_valid && out_ready && e_last) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % 8;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    in_last = '0;
    m_busy = 1'b0;
    m_owner = 0;
    m_ptr = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reset must act before any clock edge has occurred.
  task automatic test_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 8'h00) begin errors++; $display("[TB] FAIL reset_in_ready: got %h expected 00", in_ready); end
    checks++; if (sel !== 3'd0) begin errors++; $display("[TB] FAIL reset_sel: got %0d expected 0", sel); end
    do_reset();
  endtask

  // Lone requester 0 sends three beats; the pointer then favours requester 1.
  task automatic test_single_packet();
    do_reset();
    apply_stimulus(8'h01, 8'h00, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy: got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_valid: got %b expected 0", out_valid); end
    advance_clock();
    for (int b = 0; b < 3; b++) begin
      apply_stimulus(8'h01, (b == 2) ? 8'h01 : 8'h00, 1'b1);
      checks++; if (busy !== 1'b1 || sel !== 3'd0) begin errors++; $display("[TB] FAIL single_grant: got busy=%b sel=%0d expected busy=1 sel=0", busy, sel); end
      checks++; if (out_valid !== 1'b1 || in_ready !== 8'h01) begin errors++; $display("[TB] FAIL single_beat: got valid=%b ready=%h expected valid=1 ready=01", out_valid, in_ready); end
      checks++; if (out_data !== lane(0)) begin errors++; $display("[TB] FAIL single_data: got %h expected %h", out_data, lane(0)); end
      advance_clock();
    end
    apply_stimulus(8'h03, 8'h03, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_release: got %b expected 0", busy); end
    checks++; if (out_data !== lane(0) || out_last !== 1'b1) begin errors++; $display("[TB] FAIL single_idle_mux: got data=%h last=%b expected data=%h last=1", out_data, out_last, lane(0)); end
    advance_clock();
    apply_stimulus(8'h03, 8'h03, 1'b1);
    checks++; if (sel !== 3'd1) begin errors++; $display("[TB] FAIL single_next_ptr: got %0d expected 1", sel); end
    advance_clock();
  endtask

  // Everyone requesting single-beat packets: grants rotate 0..7 then 0.
  task automatic test_fair_rotation();
    do_reset();
    for (int g = 0; g < 9; g++) begin
      apply_stimulus(8'hFF, 8'hFF, 1'b1);
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rotate_bubble: got busy=%b valid=%b expected 0 0", busy, out_valid); end
      advance_clock();
      apply_stimulus(8'hFF, 8'hFF, 1'b1);
      checks++; if (busy !== 1'b1 || sel !== 3'(g % 8)) begin errors++; $display("[TB] FAIL rotate_grant: got busy=%b sel=%0d expected busy=1 sel=%0d", busy, sel, g % 8); end
      advance_clock();
    end
  endtask

  // Pointer at 6 with requesters 0 and 5: scan wraps to 0, then 5 follows.
  task automatic test_ptr_wrap();
    do_reset();
    apply_stimulus(8'h20, 8'h20, 1'b1);
    advance_clock();
    apply_stimulus(8'h20, 8'h20, 1'b1);
    checks++; if (sel !== 3'd5) begin errors++; $display("[TB] FAIL wrap_setup: got %0d expected 5", sel); end
    advance_clock();
    apply_stimulus(8'h21, 8'h21, 1'b1);
    advance_clock();
    apply_stimulus(8'h21, 8'h21, 1'b1);
    checks++; if (sel !== 3'd0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL wrap_grant0: got sel=%0d busy=%b expected sel=0 busy=1", sel, busy); end
    advance_clock();
    apply_stimulus(8'h21, 8'h21, 1'b1);
    advance_clock();
    apply_stimulus(8'h21, 8'h21, 1'b1);
    checks++; if (sel !== 3'd5 || busy !== 1'b1) begin errors++; $display("[TB] FAIL wrap_grant5: got sel=%0d busy=%b expected sel=5 busy=1", sel, busy); end
    advance_clock();
  endtask

  // Owner 3 stalled by the sink while requester 4 waits; no preemption.
  task automatic test_backpressure();
    do_reset();
    apply_stimulus(8'h08, 8'h00, 1'b1);
    advance_clock();
    for (int c = 0; c < 4; c++) begin
      apply_stimulus(8'h18, 8'h00, 1'b0);
      checks++; if (sel !== 3'd3 || busy !== 1'b1) begin errors++; $display("[TB] FAIL stall_owner: got sel=%0d busy=%b expected sel=3 busy=1", sel, busy); end
      checks++; if (in_ready !== 8'h00 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_ready: got ready=%h valid=%b expected ready=00 valid=1", in_ready, out_valid); end
      advance_clock();
    end
    apply_stimulus(8'h18, 8'h00, 1'b1);
    checks++; if (in_ready !== 8'h08 || out_data !== lane(3)) begin errors++; $display("[TB] FAIL stall_resume: got ready=%h data=%h expected ready=08 data=%h", in_ready, out_data, lane(3)); end
    advance_clock();
    apply_stimulus(8'h18, 8'h08, 1'b1);
    checks++; if (out_last !== 1'b1 || sel !== 3'd3) begin errors++; $display("[TB] FAIL stall_last: got last=%b sel=%0d expected last=1 sel=3", out_last, sel); end
    advance_clock();
    apply_stimulus(8'h18, 8'h18, 1'b1);
    advance_clock();
    apply_stimulus(8'h18, 8'h18, 1'b1);
    checks++; if (sel !== 3'd4) begin errors++; $display("[TB] FAIL stall_next: got %0d expected 4", sel); end
    advance_clock();
  endtask

  // Owner 2 drops valid for two cycles; the grant and ready are held.
  task automatic test_owner_drop();
    do_reset();
    apply_stimulus(8'h04, 8'h00, 1'b1);
    advance_clock();
    apply_stimulus(8'h04, 8'h00, 1'b1);
    checks++; if (sel !== 3'd2 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL drop_first: got sel=%0d valid=%b expected sel=2 valid=1", sel, out_valid); end
    advance_clock();
    for (int c = 0; c < 2; c++) begin
      apply_stimulus(8'h01, 8'h01, 1'b1);
      checks++; if (out_valid !== 1'b0 || busy !== 1'b1 || sel !== 3'd2) begin errors++; $display("[TB] FAIL drop_hold: got valid=%b busy=%b sel=%0d expected 0 1 2", out_valid, busy, sel); end
      checks++; if (in_ready !== 8'h04) begin errors++; $display("[TB] FAIL drop_ready: got %h expected 04", in_ready); end
      advance_clock();
    end
    apply_stimulus(8'h04, 8'h04, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_last !== 1'b1) begin errors++; $display("[TB] FAIL drop_finish: got valid=%b last=%b expected 1 1", out_valid, out_last); end
    advance_clock();
    apply_stimulus(8'h00, 8'h00, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drop_release: got %b expected 0", busy); end
    advance_clock();
  endtask

  // Reset mid-cycle during requester 5's packet, then restart from 0.
  task automatic test_reset_mid_packet();
    do_reset();
    apply_stimulus(8'h20, 8'h00, 1'b1);
    advance_clock();
    apply_stimulus(8'h20, 8'h00, 1'b1);
    checks++; if (sel !== 3'd5 || busy !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_owner: got sel=%0d busy=%b expected 5 1", sel, busy); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_drop: got busy=%b valid=%b expected 0 0", busy, out_valid); end
    checks++; if (in_ready !== 8'h00 || sel !== 3'd0) begin errors++; $display("[TB] FAIL rstmid_clear: got ready=%h sel=%0d expected 00 0", in_ready, sel); end
    m_busy = 1'b0;
    m_owner = 0;
    m_ptr = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_stimulus(8'h21, 8'h21, 1'b1);
    advance_clock();
    apply_stimulus(8'h21, 8'h21, 1'b1);
    checks++; if (sel !== 3'd0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_regrant: got sel=%0d busy=%b expected 0 1", sel, busy); end
    advance_clock();
  endtask

  // Random traffic compared every cycle against the model.
  task automatic test_random();
    logic [7:0] v;
    logic [7:0] l;
    logic       r;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      v = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      l = ($urandom_range(0, 2) == 0) ? 8'hFF : (8'($urandom) & 8'($urandom));
      r = ($urandom_range(0, 3) != 0);
      apply_stimulus(v, l, r);
      checks++; if (busy !== e_busy) begin errors++; $display("[TB] FAIL rand_busy c=%0d: got %b expected %b", c, busy, e_busy); end
      checks++; if (sel !== e_sel) begin errors++; $display("[TB] FAIL rand_sel c=%0d: got %0d expected %0d", c, sel, e_sel); end
      checks++; if (out_valid !== e_valid) begin errors++; $display("[TB] FAIL rand_valid c=%0d: got %b expected %b", c, out_valid, e_valid); end
      checks++; if (in_ready !== e_ready) begin errors++; $display("[TB] FAIL rand_ready c=%0d: got %h expected %h", c, in_ready, e_ready); end
      checks++; if (out_data !== e_data) begin errors++; $display("[TB] FAIL rand_data c=%0d: got %h expected %h", c, out_data, e_data); end
      checks++; if (out_last !== e_last) begin errors++; $display("[TB] FAIL rand_last c=%0d: got %b expected %b", c, out_last, e_last); end
      advance_clock();
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_fair_rotation();
    test_ptr_wrap();
    test_backpressure();
    test_owner_drop();
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
